// File: rtl/colour_classifier.sv
// colour_classifier: two-stage RGB box-threshold classifier with display masking.
// Optional per-class frame pixel counters are built when CC_FRAME_COUNT_EN is defined.
module colour_classifier #(
    parameter int PIX_W       = 4,
    parameter int NUM_CLASSES = 5,
    parameter int CNT_W       = 19,
    parameter int CLS_W       = $clog2(NUM_CLASSES)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PIX_W-1:0]       in_red,
    input  logic [PIX_W-1:0]       in_green,
    input  logic [PIX_W-1:0]       in_blue,
    input  logic                   in_sop,
    input  logic                   in_eop,
    input  logic                   cfg_we,
    input  logic [CLS_W-1:0]       cfg_addr,
    input  logic [6*PIX_W-1:0]     cfg_data,
    input  logic [NUM_CLASSES-1:0] disp_mask,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*PIX_W-1:0]     out_red,
    output logic [2*PIX_W-1:0]     out_green,
    output logic [2*PIX_W-1:0]     out_blue,
    output logic [NUM_CLASSES-1:0] out_hit,
    output logic                   out_sop,
    output logic                   out_eop,
    output logic                   frame_done,
    input  logic [CLS_W-1:0]       cnt_sel,
    output logic [CNT_W-1:0]       cnt_data
);

    logic [PIX_W-1:0] rmin [NUM_CLASSES];
    logic [PIX_W-1:0] rmax [NUM_CLASSES];
    logic [PIX_W-1:0] gmin [NUM_CLASSES];
    logic [PIX_W-1:0] gmax [NUM_CLASSES];
    logic [PIX_W-1:0] bmin [NUM_CLASSES];
    logic [PIX_W-1:0] bmax [NUM_CLASSES];

    logic                   s1_valid;
    logic                   s1_sop;
    logic                   s1_eop;
    logic [PIX_W-1:0]       s1_red;
    logic [PIX_W-1:0]       s1_green;
    logic [PIX_W-1:0]       s1_blue;
    logic [NUM_CLASSES-1:0] s1_hit;
    logic [NUM_CLASSES-1:0] in_hit;
    logic                   show;

    assign in_ready = !out_valid || out_ready;

    // min=all-ones / max=0 out of reset: every class is empty until programmed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
                rmin[k] <= '1;
                rmax[k] <= '0;
                gmin[k] <= '1;
                gmax[k] <= '0;
                bmin[k] <= '1;
                bmax[k] <= '0;
            end
        end else if (cfg_we && (int'(cfg_addr) < NUM_CLASSES)) begin
            {rmin[cfg_addr], rmax[cfg_addr], gmin[cfg_addr],
             gmax[cfg_addr], bmin[cfg_addr], bmax[cfg_addr]} <= cfg_data;
        end
    end

    always_comb begin
        in_hit = '0;
        for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
            in_hit[k] = (in_red   >= rmin[k]) && (in_red   <= rmax[k]) &&
                        (in_green >= gmin[k]) && (in_green <= gmax[k]) &&
                        (in_blue  >= bmin[k]) && (in_blue  <= bmax[k]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sop   <= 1'b0;
            s1_eop   <= 1'b0;
            s1_red   <= '0;
            s1_green <= '0;
            s1_blue  <= '0;
            s1_hit   <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            s1_sop   <= in_valid && in_sop;
            s1_eop   <= in_valid && in_eop;
            s1_red   <= in_red;
            s1_green <= in_green;
            s1_blue  <= in_blue;
            s1_hit   <= in_valid ? in_hit : '0;
        end
    end

    assign show = s1_valid && ((s1_hit & disp_mask) != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out_hit   <= '0;
            out_red   <= '0;
            out_green <= '0;
            out_blue  <= '0;
        end else if (in_ready) begin
            out_valid <= s1_valid;
            out_sop   <= s1_sop;
            out_eop   <= s1_eop;
            out_hit   <= s1_hit;
            out_red   <= show ? {s1_red, s1_red}     : '0;
            out_green <= show ? {s1_green, s1_green} : '0;
            out_blue  <= show ? {s1_blue, s1_blue}   : '0;
        end
    end

`ifdef CC_FRAME_COUNT_EN
    logic [CNT_W-1:0] live_cnt [NUM_CLASSES];
    logic [CNT_W-1:0] snap_cnt [NUM_CLASSES];
    logic [CNT_W-1:0] live_nxt [NUM_CLASSES];
    logic             out_hs;

    assign out_hs = out_valid && out_ready;

    // sop restarts the count with this pixel's hit; otherwise saturating increment
    always_comb begin
        for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
            live_nxt[k] = live_cnt[k];
            if (out_sop) begin
                live_nxt[k] = CNT_W'(out_hit[k]);
            end else if (out_hit[k] && (live_cnt[k] != '1)) begin
                live_nxt[k] = live_cnt[k] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done <= 1'b0;
            for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
                live_cnt[k] <= '0;
                snap_cnt[k] <= '0;
            end
        end else begin
            frame_done <= out_hs && out_eop;
            if (out_hs) begin
                for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
                    if (out_eop) begin
                        snap_cnt[k] <= live_nxt[k];
                        live_cnt[k] <= '0;
                    end else begin
                        live_cnt[k] <= live_nxt[k];
                    end
                end
            end
        end
    end

    assign cnt_data = (int'(cnt_sel) < NUM_CLASSES) ? snap_cnt[cnt_sel] : '0;
`else
    logic unused_cnt_sel;

    assign unused_cnt_sel = ^cnt_sel;
    assign frame_done     = 1'b0;
    assign cnt_data       = '0;
`endif

endmodule

// File: tb/tb_colour_classifier.sv
// Randomized self-checking bench for colour_classifier against a behavioural model
// of class matching, display masking, frame counting and saturation.
`timescale 1ns/1ps
module tb_colour_classifier;
    localparam int PIX_W = 4;
    localparam int NC    = 5;
    localparam int CNT_W = 19;
    localparam int PMAX  = (1 << PIX_W) - 1;
`ifdef CC_FRAME_COUNT_EN
    localparam bit FC_EN = 1'b1;
`else
    localparam bit FC_EN = 1'b0;
`endif

    typedef struct packed {
        logic [NC-1:0] hit;
        logic [7:0]    r;
        logic [7:0]    g;
        logic [7:0]    b;
        logic          sop;
        logic          eop;
    } pix_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid, in_ready, in_sop, in_eop;
    logic [PIX_W-1:0] in_red, in_green, in_blue;
    logic             cfg_we;
    logic [2:0]       cfg_addr;
    logic [6*PIX_W-1:0] cfg_data;
    logic [NC-1:0]    disp_mask;
    logic             out_valid, out_ready, out_sop, out_eop, frame_done;
    logic [7:0]       out_red, out_green, out_blue;
    logic [NC-1:0]    out_hit;
    logic [2:0]       cnt_sel;
    logic [CNT_W-1:0] cnt_data;
    logic [2:0]       s_cnt_data;
    logic             unused_s_in_ready, unused_s_out_valid, unused_s_sop, unused_s_eop, unused_s_fd;
    logic [7:0]       unused_s_red, unused_s_green, unused_s_blue;
    logic [NC-1:0]    unused_s_hit;

    colour_classifier #(.PIX_W(PIX_W), .NUM_CLASSES(NC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_red(in_red), .in_green(in_green), .in_blue(in_blue), .in_sop(in_sop), .in_eop(in_eop),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .disp_mask(disp_mask),
        .out_valid(out_valid), .out_ready(out_ready), .out_red(out_red), .out_green(out_green),
        .out_blue(out_blue), .out_hit(out_hit), .out_sop(out_sop), .out_eop(out_eop),
        .frame_done(frame_done), .cnt_sel(cnt_sel), .cnt_data(cnt_data)
    );

    colour_classifier #(.PIX_W(PIX_W), .NUM_CLASSES(NC), .CNT_W(3)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(unused_s_in_ready),
        .in_red(in_red), .in_green(in_green), .in_blue(in_blue), .in_sop(in_sop), .in_eop(in_eop),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .disp_mask(disp_mask),
        .out_valid(unused_s_out_valid), .out_ready(out_ready), .out_red(unused_s_red),
        .out_green(unused_s_green), .out_blue(unused_s_blue), .out_hit(unused_s_hit),
        .out_sop(unused_s_sop), .out_eop(unused_s_eop), .frame_done(unused_s_fd),
        .cnt_sel(cnt_sel), .cnt_data(s_cnt_data)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   thr [NC][6];
    int   live [NC];
    int   snap [NC];
    int   fd_count = 0;
    int   fd_bad = 0;
    bit   last_eop_hs = 1'b0;
    bit   rand_ready = 1'b0;
    pix_t exp_q[$];
    pix_t obs_q[$];
    int   exp_cyc[$];
    int   obs_cyc[$];

    function automatic logic [NC-1:0] model_hit(input int r, input int g, input int b);
        logic [NC-1:0] h;
        h = '0;
        for (int k = 0; k < NC; k++)
            h[k] = (r >= thr[k][0]) && (r <= thr[k][1]) && (g >= thr[k][2]) &&
                   (g <= thr[k][3]) && (b >= thr[k][4]) && (b <= thr[k][5]);
        return h;
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NC; k++) begin
            for (int j = 0; j < 6; j++) thr[k][j] = (j % 2 == 0) ? PMAX : 0;
            live[k] = 0;
            snap[k] = 0;
        end
        last_eop_hs = 1'b0;
        exp_q.delete(); obs_q.delete(); exp_cyc.delete(); obs_cyc.delete();
    endtask

    task automatic clear_q();
        exp_q.delete(); obs_q.delete(); exp_cyc.delete(); obs_cyc.delete();
    endtask

    // One clock: called at a falling edge, records observed outputs and feeds the model.
    task automatic tick(output bit accepted);
        pix_t          p;
        logic [NC-1:0] h;
        int            r, g, b;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        #1;
        accepted = in_valid && in_ready;
        if (frame_done !== (FC_EN && last_eop_hs)) fd_bad++;
        if (frame_done === 1'b1) fd_count++;
        last_eop_hs = out_valid && out_ready && out_eop;
        if (out_valid && out_ready) begin
            p = '{hit: out_hit, r: out_red, g: out_green, b: out_blue, sop: out_sop, eop: out_eop};
            obs_q.push_back(p);
            obs_cyc.push_back(cyc);
        end
        if (accepted) begin
            r = int'(in_red); g = int'(in_green); b = int'(in_blue);
            h = model_hit(r, g, b);
            p.hit = h;
            p.sop = in_sop;
            p.eop = in_eop;
            if ((h & disp_mask) != 0) begin
                p.r = 8'(r * (PMAX + 2)); p.g = 8'(g * (PMAX + 2)); p.b = 8'(b * (PMAX + 2));
            end else begin
                p.r = 8'd0; p.g = 8'd0; p.b = 8'd0;
            end
            exp_q.push_back(p);
            exp_cyc.push_back(cyc);
            for (int k = 0; k < NC; k++) live[k] = in_sop ? int'(h[k]) : live[k] + int'(h[k]);
            if (in_eop) begin
                for (int k = 0; k < NC; k++) begin snap[k] = live[k]; live[k] = 0; end
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic send(input int r, input int g, input int b, input bit sop, input bit eop);
        bit acc;
        acc = 1'b0;
        in_valid = 1'b1; in_red = 4'(r); in_green = 4'(g); in_blue = 4'(b);
        in_sop = sop; in_eop = eop;
        for (int t = 0; t < 100 && !acc; t++) tick(acc);
        if (!acc) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready stuck low for 100 cycles, needed 1");
        end
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    endtask

    task automatic flush();
        bit acc;
        in_valid = 1'b0;
        for (int t = 0; t < 300 && obs_q.size() < exp_q.size(); t++) tick(acc);
        repeat (2) tick(acc);
    endtask

    task automatic write_cfg(input int addr, input int a0, input int a1, input int a2,
                             input int a3, input int a4, input int a5);
        bit acc;
        cfg_we = 1'b1; cfg_addr = 3'(addr);
        cfg_data = {4'(a0), 4'(a1), 4'(a2), 4'(a3), 4'(a4), 4'(a5)};
        tick(acc);
        cfg_we = 1'b0;
        if (addr < NC) begin
            thr[addr][0] = a0; thr[addr][1] = a1; thr[addr][2] = a2;
            thr[addr][3] = a3; thr[addr][4] = a4; thr[addr][5] = a5;
        end
    endtask

    task automatic test_reset();
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        checks += 6;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b need 0", out_valid); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b need 1", in_ready); end
        if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b need 0", frame_done); end
        if (out_hit !== '0) begin errors++; $display("FAIL reset_out_hit: got %b need 0", out_hit); end
        if ({out_red, out_green, out_blue, out_sop, out_eop} !== '0) begin
            errors++; $display("FAIL reset_out_data: got %h need 0", {out_red, out_green, out_blue});
        end
        if (cnt_data !== '0) begin errors++; $display("FAIL reset_cnt_data: got %0d need 0", cnt_data); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b need 1", in_ready); end
    endtask

    task automatic test_match();
        out_ready = 1'b1; rand_ready = 1'b0;
        write_cfg(3, 8, 15, 2, 5, 0, 5);
        for (int pass = 0; pass < 2; pass++) begin
            clear_q();
            disp_mask = (pass == 0) ? 5'b01000 : 5'b00000;
            send(10, 3, 2, 1'b0, 1'b0);
            flush();
            checks += 4;
            if (obs_q.size() != 1) begin
                errors++; $display("FAIL match_count: got %0d outputs need 1", obs_q.size());
            end else begin
                if (obs_q[0].hit !== 5'b01000) begin
                    errors++; $display("FAIL match_hit: got %b need 01000", obs_q[0].hit);
                end
                if ({obs_q[0].r, obs_q[0].g, obs_q[0].b} !== ((pass == 0) ? 24'hAA3322 : 24'h0)) begin
                    errors++; $display("FAIL match_rgb[%0d]: got %h", pass, {obs_q[0].r, obs_q[0].g, obs_q[0].b});
                end
                if (obs_cyc[0] - exp_cyc[0] != 2) begin
                    errors++; $display("FAIL match_latency: got %0d need 2", obs_cyc[0] - exp_cyc[0]);
                end
            end
        end
        // a min>max class never matches, even for a pixel inside both bounds' span
        write_cfg(2, 9, 4, 0, 15, 0, 15);
        clear_q();
        disp_mask = 5'b11111;
        send(6, 7, 8, 1'b0, 1'b0);
        flush();
        checks++;
        if (obs_q.size() != 1 || obs_q[0].hit !== 5'b00000) begin
            errors++; $display("FAIL inverted_class: got %b need 00000", (obs_q.size() != 0) ? obs_q[0].hit : 5'bx);
        end
    endtask

    task automatic test_stall();
        logic [31:0] held;
        bit          acc;
        int          px [4][3];
        clear_q();
        out_ready = 1'b1; rand_ready = 1'b0; disp_mask = 5'b11111;
        for (int i = 0; i < 4; i++)
            for (int c = 0; c < 3; c++) px[i][c] = $urandom_range(0, PMAX);
        px[1][0] = 12; px[1][1] = 4; px[1][2] = 3;
        send(px[0][0], px[0][1], px[0][2], 1'b0, 1'b0);
        send(px[1][0], px[1][1], px[1][2], 1'b0, 1'b0);
        out_ready = 1'b0;
        in_valid = 1'b1; in_red = 4'(px[2][0]); in_green = 4'(px[2][1]); in_blue = 4'(px[2][2]);
        #1;
        held = {out_valid, out_red, out_green, out_blue, out_hit, out_sop, out_eop};
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_first_out: got %b need 1", out_valid); end
        for (int i = 0; i < 3; i++) begin
            checks += 2;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d]: got %b need 0", i, in_ready); end
            tick(acc);
            if ({out_valid, out_red, out_green, out_blue, out_hit, out_sop, out_eop} !== held) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got %h need %h", i,
                         {out_valid, out_red, out_green, out_blue, out_hit, out_sop, out_eop}, held);
            end
        end
        out_ready = 1'b1;
        send(px[2][0], px[2][1], px[2][2], 1'b0, 1'b0);
        send(px[3][0], px[3][1], px[3][2], 1'b0, 1'b0);
        flush();
        checks++;
        if (obs_q.size() != 4) begin errors++; $display("FAIL stall_count: got %0d need 4", obs_q.size()); end
        for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL stall_pix[%0d]: got %h need %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_frame_count();
        int lens [4] = '{10, 3, 12, 1};
        int nm   [4] = '{7, 1, 12, 1};
        int rem, fd0, r;
        bit m;
        out_ready = 1'b1; rand_ready = 1'b0;
        write_cfg(0, 0, 7, 0, 15, 0, 15);
        for (int s = 0; s < 4; s++) begin
            clear_q();
            disp_mask = 5'($urandom_range(0, 31));
            fd0 = fd_count;
            rem = nm[s];
            for (int i = 0; i < lens[s]; i++) begin
                m = ($urandom_range(0, lens[s] - 1 - i) < rem);
                if (m) rem--;
                r = m ? $urandom_range(0, 7) : $urandom_range(8, 15);
                send(r, $urandom_range(0, PMAX), $urandom_range(0, PMAX), i == 0, i == lens[s] - 1);
            end
            flush();
            checks += 5;
            if (obs_q.size() != lens[s]) begin
                errors++; $display("FAIL frame_out_count[%0d]: got %0d need %0d", s, obs_q.size(), lens[s]);
            end
            if (fd_count - fd0 != (FC_EN ? 1 : 0)) begin
                errors++; $display("FAIL frame_done_pulses[%0d]: got %0d need %0d", s, fd_count - fd0, FC_EN);
            end
            if (fd_bad != 0) begin errors++; $display("FAIL frame_done_timing[%0d]: got %0d bad cycles need 0", s, fd_bad); end
            cnt_sel = 3'd0;
            #1;
            if (cnt_data !== CNT_W'(FC_EN ? nm[s] : 0)) begin
                errors++; $display("FAIL frame_cnt0[%0d]: got %0d need %0d", s, cnt_data, FC_EN ? nm[s] : 0);
            end
            if (s_cnt_data !== 3'(FC_EN ? imin(nm[s], 7) : 0)) begin
                errors++; $display("FAIL sat_cnt0[%0d]: got %0d need %0d", s, s_cnt_data, FC_EN ? imin(nm[s], 7) : 0);
            end
            for (int i = 0; i < lens[s] && i < obs_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++; $display("FAIL frame_pix[%0d][%0d]: got %h need %h", s, i, obs_q[i], exp_q[i]);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        int len, fd0, a, b;
        bit acc;
        for (int k = 0; k < NC - 1; k++) begin
            int t [6];
            for (int c = 0; c < 3; c++) begin
                a = $urandom_range(0, PMAX); b = $urandom_range(0, PMAX);
                t[2*c] = imin(a, b); t[2*c+1] = (a < b) ? b : a;
            end
            write_cfg(k, t[0], t[1], t[2], t[3], t[4], t[5]);
        end
        write_cfg(NC - 1, $urandom_range(8, 15), $urandom_range(0, 7), 0, 15, 0, 15);
        write_cfg($urandom_range(NC, 7), 0, 15, 0, 15, 0, 15);
        disp_mask = 5'($urandom_range(0, 31));
        rand_ready = 1'b1;
        for (int f = 0; f < 4; f++) begin
            clear_q();
            fd0 = fd_count;
            len = $urandom_range(1, 16);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) tick(acc);
                send($urandom_range(0, PMAX), $urandom_range(0, PMAX), $urandom_range(0, PMAX),
                     i == 0, i == len - 1);
            end
            flush();
            checks += 3;
            if (obs_q.size() != len) begin
                errors++; $display("FAIL rand_out_count[%0d]: got %0d need %0d", f, obs_q.size(), len);
            end
            if (fd_count - fd0 != (FC_EN ? 1 : 0)) begin
                errors++; $display("FAIL rand_frame_done[%0d]: got %0d need %0d", f, fd_count - fd0, FC_EN);
            end
            if (fd_bad != 0) begin errors++; $display("FAIL rand_fd_timing[%0d]: got %0d need 0", f, fd_bad); end
            for (int i = 0; i < len && i < obs_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++; $display("FAIL rand_pix[%0d][%0d]: got %h need %h", f, i, obs_q[i], exp_q[i]);
                end
            end
            for (int k = 0; k < 8; k++) begin
                cnt_sel = 3'(k);
                #1;
                checks++;
                if (cnt_data !== CNT_W'((FC_EN && k < NC) ? snap[k] : 0)) begin
                    errors++; $display("FAIL rand_cnt[%0d][%0d]: got %0d need %0d", f, k, cnt_data,
                                       (FC_EN && k < NC) ? snap[k] : 0);
                end
            end
            @(negedge clk);
        end
        rand_ready = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset_mid();
        int fd0;
        out_ready = 1'b1; rand_ready = 1'b0;
        write_cfg(1, 0, 15, 0, 15, 0, 15);
        disp_mask = 5'b00010;
        clear_q();
        fd0 = fd_count;
        for (int i = 0; i < 5; i++)
            send($urandom_range(0, PMAX), $urandom_range(0, PMAX), $urandom_range(0, PMAX), i == 0, 1'b0);
        rst_n = 1'b0;
        #1;
        checks += 5;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b need 0", out_valid); end
        if (out_hit !== '0) begin errors++; $display("FAIL midrst_out_hit: got %b need 0", out_hit); end
        if ({out_red, out_green, out_blue, out_sop, out_eop} !== '0) begin
            errors++; $display("FAIL midrst_out_data: got %h need 0", {out_red, out_green, out_blue});
        end
        if (frame_done !== 1'b0) begin errors++; $display("FAIL midrst_frame_done: got %b need 0", frame_done); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b need 1", in_ready); end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(5, 5, 5, 1'b0, 1'b0);
        flush();
        checks += 3;
        if (obs_q.size() != 1) begin errors++; $display("FAIL midrst_count: got %0d need 1", obs_q.size()); end
        else if (obs_q[0] !== exp_q[0] || obs_q[0].hit !== '0) begin
            errors++; $display("FAIL midrst_nomatch: got %h need %h", obs_q[0], exp_q[0]);
        end
        if (fd_count != fd0) begin errors++; $display("FAIL midrst_no_fd: got %0d pulses need 0", fd_count - fd0); end
        for (int k = 0; k < NC; k++) begin
            cnt_sel = 3'(k);
            #1;
            checks++;
            if (cnt_data !== CNT_W'(snap[k])) begin
                errors++; $display("FAIL midrst_snap[%0d]: got %0d need 0", k, cnt_data);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        in_red = '0; in_green = '0; in_blue = '0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        disp_mask = '0; out_ready = 1'b1; cnt_sel = '0;
        test_reset();
        test_match();
        test_stall();
        test_frame_count();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
